// File: rtl/seq_gen_pkg.sv
// Shared constants and types for the additive-sequence accelerator.
package seq_gen_pkg;

    // Word register offsets on the Avalon-MM slave
    localparam logic [2:0] REG_LIMIT  = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_RESULT = 3'd3;
    localparam logic [2:0] REG_SEED0  = 3'd4;
    localparam logic [2:0] REG_SEED1  = 3'd5;
    localparam logic [2:0] REG_COUNT  = 3'd6;

    // CTRL bit positions
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_MODE   = 1;
    localparam int unsigned CTRL_ABORT  = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    // STATUS bit positions
    localparam int unsigned STAT_DONE    = 0;
    localparam int unsigned STAT_BUSY    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_ABORTED = 3;

    // Stop-mode encoding of CTRL.MODE
    localparam logic MODE_LIMIT = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

    // Seed reset values give the classic Fibonacci sequence
    localparam int unsigned SEED0_RST = 0;
    localparam int unsigned SEED1_RST = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_gen_core.sv
// Sequence engine: one term per cycle, stops on value limit, term count,
// adder carry or index saturation. Stop/abort outputs are combinational and
// valid in the final RUN cycle so the register file latches them on the
// same edge the FSM returns to IDLE.
module seq_gen_core
    import seq_gen_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [DATA_W-1:0] limit,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              aborted,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned CMP_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;
    localparam logic [CNT_W-1:0] IDX_MAX = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W:0]   sum;
    logic              count_hit;
    logic              limit_hit;

    // One extra bit so the carry doubles as the overflow flag
    assign sum       = {1'b0, cur_q} + {1'b0, prev_q};
    assign count_hit = CMP_W'(idx_q) == CMP_W'(limit);
    assign limit_hit = sum > {1'b0, limit};
    assign busy      = (state_q == ST_RUN);

    // Next-state, datapath update and stop decode
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        done    = 1'b0;
        ovf     = 1'b0;
        aborted = 1'b0;
        result  = '0;
        count   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    prev_d  = seed0;
                    cur_d   = seed1;
                    idx_d   = CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    aborted = 1'b1;
                end else if (mode == MODE_COUNT && limit == '0) begin
                    // Term 0 requested: report the first seed
                    state_d = ST_IDLE;
                    done    = 1'b1;
                    result  = prev_q;
                end else if (mode == MODE_LIMIT && cur_q > limit) begin
                    // Only reachable in the first cycle: SEED1 already beyond the bound
                    state_d = ST_IDLE;
                    done    = 1'b1;
                    result  = (prev_q <= limit) ? prev_q : '0;
                end else if ((mode == MODE_COUNT) ? count_hit : limit_hit) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                    result  = cur_q;
                    count   = idx_q;
                end else if (sum[DATA_W] || idx_q == IDX_MAX) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                    ovf     = 1'b1;
                    result  = cur_q;
                    count   = idx_q;
                end else begin
                    prev_d = cur_q;
                    cur_d  = sum[DATA_W-1:0];
                    idx_d  = idx_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and term registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/seq_gen_accel.sv
// Avalon-MM slave wrapper: register file, read mux, irq, and the sequence core.
module seq_gen_accel
    import seq_gen_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic              wr, rd;
    logic              start_req, abort_req;
    logic              core_busy, core_done, core_ovf, core_aborted;
    logic [DATA_W-1:0] core_result;
    logic [CNT_W-1:0]  core_count;

    logic [DATA_W-1:0] limit_q, limit_d;
    logic [DATA_W-1:0] seed0_q, seed0_d;
    logic [DATA_W-1:0] seed1_q, seed1_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mode_q, mode_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              aborted_q, aborted_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [31:0]       rmux;

    assign wr = chipselect & write;
    assign rd = chipselect & read;

    // ABORT in the same write suppresses START
    assign start_req = wr && address == REG_CTRL && writedata[CTRL_START]
                       && !writedata[CTRL_ABORT] && !core_busy;
    assign abort_req = wr && address == REG_CTRL && writedata[CTRL_ABORT];

    assign readdata = readdata_q;
    assign irq      = done_q & irq_en_q;

    seq_gen_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_req),
        .abort   (abort_req),
        .mode    (mode_q),
        .limit   (limit_q),
        .seed0   (seed0_q),
        .seed1   (seed1_q),
        .busy    (core_busy),
        .done    (core_done),
        .ovf     (core_ovf),
        .aborted (core_aborted),
        .result  (core_result),
        .count   (core_count)
    );

    // Register-file next state; hardware sets are applied last so they win over w1c
    always_comb begin
        limit_d   = limit_q;
        seed0_d   = seed0_q;
        seed1_d   = seed1_q;
        result_d  = result_q;
        count_d   = count_q;
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        aborted_d = aborted_q;

        if (wr && !core_busy) begin
            case (address)
                REG_LIMIT:  limit_d  = writedata;
                REG_RESULT: result_d = writedata;
                REG_SEED0:  seed0_d  = writedata;
                REG_SEED1:  seed1_d  = writedata;
                REG_COUNT:  count_d  = CNT_W'(writedata);
                default:    ;
            endcase
        end
        if (wr && address == REG_CTRL) begin
            irq_en_d = writedata[CTRL_IRQ_EN];
            // Mode is frozen while a run is in flight
            if (!core_busy) begin
                mode_d = writedata[CTRL_MODE];
            end
        end
        if (wr && address == REG_STATUS) begin
            if (writedata[STAT_DONE]) done_d = 1'b0;
            if (writedata[STAT_OVF]) ovf_d = 1'b0;
            if (writedata[STAT_ABORTED]) aborted_d = 1'b0;
        end
        if (start_req) begin
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            aborted_d = 1'b0;
        end
        if (core_done) begin
            done_d   = 1'b1;
            result_d = core_result;
            count_d  = core_count;
        end
        if (core_ovf) ovf_d = 1'b1;
        if (core_aborted) aborted_d = 1'b1;
    end

    // Read mux, zero-extended to a 32-bit word
    always_comb begin
        rmux = '0;
        case (address)
            REG_LIMIT:  rmux = 32'(limit_q);
            REG_CTRL: begin
                rmux[CTRL_MODE]   = mode_q;
                rmux[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_STATUS: begin
                rmux[STAT_DONE]    = done_q;
                rmux[STAT_BUSY]    = core_busy;
                rmux[STAT_OVF]     = ovf_q;
                rmux[STAT_ABORTED] = aborted_q;
            end
            REG_RESULT: rmux = 32'(result_q);
            REG_SEED0:  rmux = 32'(seed0_q);
            REG_SEED1:  rmux = 32'(seed1_q);
            REG_COUNT:  rmux = 32'(count_q);
            default:    rmux = '0;
        endcase
        readdata_d = rd ? rmux[DATA_W-1:0] : '0;
    end

    // Register file and registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit_q    <= '0;
            seed0_q    <= DATA_W'(SEED0_RST);
            seed1_q    <= DATA_W'(SEED1_RST);
            result_q   <= '0;
            count_q    <= '0;
            mode_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            aborted_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            limit_q    <= limit_d;
            seed0_q    <= seed0_d;
            seed1_q    <= seed1_d;
            result_q   <= result_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            aborted_q  <= aborted_d;
            readdata_q <= readdata_d;
        end
    end

endmodule

// File: tb/tb_seq_gen_accel.sv
// Bench for seq_gen_accel: directed scenarios plus randomized runs against a
// term-table reference model.
module tb_seq_gen_accel;

    localparam logic [2:0] A_LIMIT = 3'd0, A_CTRL = 3'd1, A_STATUS = 3'd2, A_RESULT = 3'd3;
    localparam logic [2:0] A_SEED0 = 3'd4, A_SEED1 = 3'd5, A_COUNT = 3'd6;
    localparam longint BIG = 64'sh1_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    seq_gen_accel #(
        .DATA_W (32),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Callers are at a falling edge; the write is captured on the next rising edge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Poll STATUS.BUSY with a bounded budget
    task automatic wait_idle(input string name);
        logic [31:0] st;
        bit          idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            bus_read(A_STATUS, st);
            if (!st[1]) idle = 1'b1;
        end
        tests_run++;
        if (!idle) begin
            tests_failed++;
            $display("FAIL %s timeout: BUSY still 1, required 0", name);
        end
    endtask

    // Reference: build the term table t[k], then pick the stop index from the rules
    function automatic void ref_model(input longint s0, input longint s1, input longint lim,
                                      input bit cnt_mode, output longint res,
                                      output longint cnt, output bit ovf);
        longint t[100];
        t[0] = s0;
        t[1] = s1;
        for (int k = 2; k < 100; k++) begin
            t[k] = t[k-1] + t[k-2];
            if (t[k] > 2 * BIG) t[k] = 2 * BIG;
        end
        res = 0; cnt = 0; ovf = 1'b0;
        if (cnt_mode) begin
            if (lim == 0) begin
                res = s0;
            end else begin
                cnt = lim;
                for (int k = 1; k < lim; k++) begin
                    if (t[k+1] >= BIG) begin
                        cnt = k; ovf = 1'b1; break;
                    end
                end
                res = t[cnt];
            end
        end else if (s1 > lim) begin
            res = (s0 <= lim) ? s0 : 0;
        end else begin
            for (int k = 1; k < 99; k++) begin
                if (t[k+1] > lim) begin
                    cnt = k; break;
                end
            end
            res = t[cnt];
        end
    endfunction

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rst [8];
        exp_rst = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++; $display("FAIL reset_irq: got %b want 0", irq);
        end
        tests_run++;
        if (readdata !== 32'd0) begin
            tests_failed++; $display("FAIL reset_readdata: got %0h want 0", readdata);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            tests_run++;
            if (rd !== exp_rst[a]) begin
                tests_failed++; $display("FAIL reset_reg%0d: got %0h want %0h", a, rd, exp_rst[a]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (readdata !== 32'd0) begin
            tests_failed++; $display("FAIL idle_readdata: got %0h want 0", readdata);
        end
    endtask

    task automatic test_fib_limit();
        logic [31:0] rd;
        bus_write(A_LIMIT, 32'd100);
        bus_write(A_CTRL, 32'h9);
        wait_idle("fib_limit");
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd89) begin
            tests_failed++; $display("FAIL fib_result: got %0d want 89", rd);
        end
        bus_read(A_COUNT, rd);
        tests_run++;
        if (rd !== 32'd11) begin
            tests_failed++; $display("FAIL fib_count: got %0d want 11", rd);
        end
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h1) begin
            tests_failed++; $display("FAIL fib_status: got %0h want 1", rd);
        end
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++; $display("FAIL fib_irq: got %b want 1", irq);
        end
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL w1c_done: status %0h irq %b want 0 0", rd, irq);
        end
    endtask

    task automatic test_lucas_count();
        logic [31:0] rd;
        bus_write(A_SEED0, 32'd2);
        bus_write(A_SEED1, 32'd1);
        bus_write(A_LIMIT, 32'd10);
        bus_write(A_CTRL, 32'h3);
        wait_idle("lucas");
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd123) begin
            tests_failed++; $display("FAIL lucas_result: got %0d want 123", rd);
        end
        bus_read(A_COUNT, rd);
        tests_run++;
        if (rd !== 32'd10) begin
            tests_failed++; $display("FAIL lucas_count: got %0d want 10", rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bus_write(A_SEED0, 32'd0);
        bus_write(A_SEED1, 32'd1);
        bus_write(A_LIMIT, 32'd60);
        bus_write(A_CTRL, 32'h3);
        wait_idle("overflow");
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h5) begin
            tests_failed++; $display("FAIL ovf_status: got %0h want 5", rd);
        end
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd2971215073) begin
            tests_failed++; $display("FAIL ovf_result: got %0d want 2971215073", rd);
        end
        bus_read(A_COUNT, rd);
        tests_run++;
        if (rd !== 32'd47) begin
            tests_failed++; $display("FAIL ovf_count: got %0d want 47", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        bus_write(A_LIMIT, 32'd1000);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++; $display("FAIL run_status: got %0h want 2", rd);
        end
        repeat (5) @(negedge clk);
        bus_write(A_LIMIT, 32'd7);
        bus_write(A_SEED0, 32'd9);
        bus_read(A_LIMIT, rd);
        tests_run++;
        if (rd !== 32'd1000) begin
            tests_failed++; $display("FAIL busy_limit_write: got %0d want 1000", rd);
        end
        bus_write(A_CTRL, 32'h4);
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h8) begin
            tests_failed++; $display("FAIL abort_status: got %0h want 8", rd);
        end
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd2971215073) begin
            tests_failed++; $display("FAIL abort_result_kept: got %0d want 2971215073", rd);
        end
        bus_read(A_SEED0, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++; $display("FAIL busy_seed_write: got %0d want 0", rd);
        end
        bus_read(A_CTRL, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++; $display("FAIL abort_ctrl: got %0h want 2", rd);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd;
        logic [31:0] exp_rst [8];
        exp_rst = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
        bus_write(A_SEED0, 32'd2);
        bus_write(A_LIMIT, 32'd10);
        bus_write(A_CTRL, 32'hB);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_irq: got %b want 0", irq);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            tests_run++;
            if (rd !== exp_rst[a]) begin
                tests_failed++;
                $display("FAIL midreset_reg%0d: got %0h want %0h", a, rd, exp_rst[a]);
            end
        end
        bus_write(A_LIMIT, 32'd100);
        bus_write(A_CTRL, 32'h9);
        wait_idle("restart");
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd89) begin
            tests_failed++; $display("FAIL restart_result: got %0d want 89", rd);
        end
        bus_read(A_COUNT, rd);
        tests_run++;
        if (rd !== 32'd11 || irq !== 1'b1) begin
            tests_failed++; $display("FAIL restart_count_irq: got %0d/%b want 11/1", rd, irq);
        end
    endtask

    task automatic test_edge_cases();
        logic [31:0] rd;
        bus_write(A_LIMIT, 32'd0);
        bus_write(A_CTRL, 32'h3);
        wait_idle("count0");
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++; $display("FAIL count0_result: got %0d want 0", rd);
        end
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h1) begin
            tests_failed++; $display("FAIL count0_status: got %0h want 1", rd);
        end
        // ABORT while idle, and START+ABORT together, must leave everything alone
        bus_write(A_CTRL, 32'h4);
        bus_write(A_CTRL, 32'h5);
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h1) begin
            tests_failed++; $display("FAIL idle_abort_status: got %0h want 1", rd);
        end
        // Start a one-cycle run and w1c DONE on the very edge that sets it
        bus_write(A_SEED0, 32'd5);
        bus_write(A_CTRL, 32'h3);
        bus_write(A_STATUS, 32'h1);
        repeat (2) @(negedge clk);
        bus_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h1) begin
            tests_failed++; $display("FAIL w1c_race_done: got %0h want 1", rd);
        end
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd5) begin
            tests_failed++; $display("FAIL count0_seed0: got %0d want 5", rd);
        end
        bus_write(A_SEED0, 32'd3);
        bus_write(A_SEED1, 32'd50);
        bus_write(A_LIMIT, 32'd10);
        bus_write(A_CTRL, 32'h1);
        wait_idle("seed1_over");
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd3) begin
            tests_failed++; $display("FAIL seed1_over_result: got %0d want 3", rd);
        end
        bus_write(A_SEED0, 32'd20);
        bus_write(A_CTRL, 32'h1);
        wait_idle("both_over");
        bus_read(A_RESULT, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++; $display("FAIL both_over_result: got %0d want 0", rd);
        end
        bus_read(A_COUNT, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++; $display("FAIL both_over_count: got %0d want 0", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, s0, s1, lim;
        bit          md, e_ovf;
        longint      e_res, e_cnt;
        for (int it = 0; it < 12; it++) begin
            md = 1'($urandom_range(0, 1));
            s0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 50));
            s1 = 32'($urandom_range(1, 50));
            if (md) lim = 32'($urandom_range(0, 60));
            else lim = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ref_model(s0, s1, lim, md, e_res, e_cnt, e_ovf);
            bus_write(A_SEED0, s0);
            bus_write(A_SEED1, s1);
            bus_write(A_LIMIT, lim);
            bus_write(A_CTRL, {30'd0, md, 1'b1});
            wait_idle("random");
            bus_read(A_RESULT, rd);
            tests_run++;
            if (rd !== e_res[31:0]) begin
                tests_failed++;
                $display("FAIL rand_result s0=%0d s1=%0d lim=%0d mode=%0d: got %0d want %0d",
                         s0, s1, lim, md, rd, e_res);
            end
            bus_read(A_COUNT, rd);
            tests_run++;
            if (rd !== e_cnt[31:0]) begin
                tests_failed++;
                $display("FAIL rand_count lim=%0d mode=%0d: got %0d want %0d", lim, md, rd, e_cnt);
            end
            bus_read(A_STATUS, rd);
            tests_run++;
            if (rd !== {29'd0, e_ovf, 2'b01}) begin
                tests_failed++;
                $display("FAIL rand_status: got %0h want %0h", rd, {29'd0, e_ovf, 2'b01});
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fib_limit();
        test_lucas_count();
        test_overflow();
        test_abort();
        test_reset_mid_run();
        test_edge_cases();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
